// File: rtl/obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : obi_rr_arbiter
// Description : Two-master round-robin OBI arbiter in front of a single
//               memory port. Keeps one transaction outstanding and holds the
//               downstream request until the response returns.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_rr_arbiter #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                     core_clk_i,
  input  logic                     rstn_i,
  // master 0
  input  logic                     m0_req_i,
  output logic                     m0_gnt_o,
  input  logic [AddrWidth-1:0]     m0_addr_i,
  input  logic                     m0_we_i,
  input  logic [DataWidth-1:0]     m0_wdata_i,
  input  logic [DataWidth/8-1:0]   m0_be_i,
  output logic                     m0_rvalid_o,
  output logic [DataWidth-1:0]     m0_rdata_o,
  output logic                     m0_err_o,
  // master 1
  input  logic                     m1_req_i,
  output logic                     m1_gnt_o,
  input  logic [AddrWidth-1:0]     m1_addr_i,
  input  logic                     m1_we_i,
  input  logic [DataWidth-1:0]     m1_wdata_i,
  input  logic [DataWidth/8-1:0]   m1_be_i,
  output logic                     m1_rvalid_o,
  output logic [DataWidth-1:0]     m1_rdata_o,
  output logic                     m1_err_o,
  // downstream memory port
  output logic                     s_req_o,
  input  logic                     s_gnt_i,
  output logic [AddrWidth-1:0]     s_addr_o,
  output logic                     s_we_o,
  output logic [DataWidth-1:0]     s_wdata_o,
  output logic [DataWidth/8-1:0]   s_be_o,
  input  logic                     s_rvalid_i,
  input  logic [DataWidth-1:0]     s_rdata_i,
  input  logic                     s_err_i,
  // status
  output logic                     busy_o,
  output logic                     owner_o
);

  localparam int unsigned c_BE_WIDTH = DataWidth / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    prio_q,  prio_d;
  logic [AddrWidth-1:0]    addr_q,  addr_d;
  logic                    we_q,    we_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [c_BE_WIDTH-1:0]   be_q,    be_d;

  logic w_busy;
  logic w_any_req;
  logic w_sel;
  logic w_hs;
  logic w_route;
  logic w_deliver;

  // Selection and handshake decode; a lone requester wins, a tie goes to prio_q
  always_comb begin
    w_busy    = (state_q == BUSY);
    w_any_req = m0_req_i | m1_req_i;
    w_sel     = (m0_req_i & m1_req_i) ? prio_q : m1_req_i;
    w_hs      = ~w_busy & w_any_req & s_gnt_i;
    // The response belongs to the live winner only when it completes the
    // handshake in the same cycle; a stray rvalid in IDLE is dropped.
    w_route   = w_busy ? owner_q : w_sel;
    w_deliver = w_busy ? s_rvalid_i : (w_hs & s_rvalid_i);
  end

  // Downstream command, grants and response routing; handshakes masked in reset
  always_comb begin
    s_req_o     = rstn_i & (w_busy | w_any_req);
    s_addr_o    = w_busy ? addr_q  : (w_sel ? m1_addr_i  : m0_addr_i);
    s_we_o      = w_busy ? we_q    : (w_sel ? m1_we_i    : m0_we_i);
    s_wdata_o   = w_busy ? wdata_q : (w_sel ? m1_wdata_i : m0_wdata_i);
    s_be_o      = w_busy ? be_q    : (w_sel ? m1_be_i    : m0_be_i);

    m0_gnt_o    = rstn_i & ~w_busy & ~w_sel & s_gnt_i;
    m1_gnt_o    = rstn_i & ~w_busy &  w_sel & s_gnt_i;

    m0_rvalid_o = rstn_i & w_deliver & ~w_route;
    m1_rvalid_o = rstn_i & w_deliver &  w_route;
    m0_err_o    = m0_rvalid_o & s_err_i;
    m1_err_o    = m1_rvalid_o & s_err_i;
    m0_rdata_o  = s_rdata_i;
    m1_rdata_o  = s_rdata_i;

    busy_o      = w_busy;
    owner_o     = owner_q;
  end

  // Next-state: capture the command on handshake, rotate priority on response
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (w_hs) begin
          owner_d = w_sel;
          addr_d  = s_addr_o;
          we_d    = s_we_o;
          wdata_d = s_wdata_o;
          be_d    = s_be_o;
          if (s_rvalid_i) begin
            prio_d = ~w_sel;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (s_rvalid_i) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and command registers
  always_ff @(posedge core_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_rr_arbiter
// Description : Self-checking bench for obi_rr_arbiter: transaction-level
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          m0_req, m1_req, m0_gnt, m1_gnt;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic          m0_we, m1_we, s_we;
  logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
  logic [BW-1:0] m0_be, m1_be, s_be;
  logic          m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic          s_req, s_gnt, s_rvalid, s_err;
  logic          busy, owner;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  obi_rr_arbiter #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .core_clk_i(clk),       .rstn_i(rstn),
    .m0_req_i(m0_req),      .m0_gnt_o(m0_gnt),     .m0_addr_i(m0_addr),
    .m0_we_i(m0_we),        .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
    .m0_rvalid_o(m0_rvalid),.m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req),      .m1_gnt_o(m1_gnt),     .m1_addr_i(m1_addr),
    .m1_we_i(m1_we),        .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
    .m1_rvalid_o(m1_rvalid),.m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .s_req_o(s_req),        .s_gnt_i(s_gnt),       .s_addr_o(s_addr),
    .s_we_o(s_we),          .s_wdata_o(s_wdata),   .s_be_o(s_be),
    .s_rvalid_i(s_rvalid),  .s_rdata_i(s_rdata),   .s_err_i(s_err),
    .busy_o(busy),          .owner_o(owner)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pending transaction record (at most one), the master to favour on a
  // tie, and the last master granted.
  logic          md_pending, nx_pending;
  logic          md_owner,   nx_owner;
  logic          md_favour,  nx_favour;
  logic [AW-1:0] md_addr,  nx_addr;
  logic          md_we,    nx_we;
  logic [DW-1:0] md_wdata, nx_wdata;
  logic [BW-1:0] md_be,    nx_be;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      md_pending <= 1'b0; md_owner <= 1'b0; md_favour <= 1'b0;
      md_addr <= '0; md_we <= 1'b0; md_wdata <= '0; md_be <= '0;
    end else begin
      md_pending <= nx_pending; md_owner <= nx_owner; md_favour <= nx_favour;
      md_addr <= nx_addr; md_we <= nx_we; md_wdata <= nx_wdata; md_be <= nx_be;
    end
  end

  // Compare process: derive expected outputs from the model plus live inputs
  always @(negedge clk) begin
    logic          req [2];
    logic [AW-1:0] la  [2];
    logic          lw  [2];
    logic [DW-1:0] ld  [2];
    logic [BW-1:0] lb  [2];
    logic          e_gnt [2];
    logic          e_rv  [2];
    logic          e_sreq, win, hs, deliver, dest;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;
    req[0] = m0_req;   req[1] = m1_req;
    la[0]  = m0_addr;  la[1]  = m1_addr;
    lw[0]  = m0_we;    lw[1]  = m1_we;
    ld[0]  = m0_wdata; ld[1]  = m1_wdata;
    lb[0]  = m0_be;    lb[1]  = m1_be;
    e_gnt[0] = 1'b0; e_gnt[1] = 1'b0;
    e_rv[0]  = 1'b0; e_rv[1]  = 1'b0;
    win = (req[0] && req[1]) ? md_favour : req[1];
    hs  = 1'b0;
    if (md_pending) begin
      e_sreq = 1'b1;
      e_addr = md_addr; e_we = md_we; e_wdata = md_wdata; e_be = md_be;
      dest    = md_owner;
      deliver = s_rvalid;
    end else begin
      e_sreq = req[0] || req[1];
      e_addr = la[win]; e_we = lw[win]; e_wdata = ld[win]; e_be = lb[win];
      e_gnt[win] = s_gnt;
      hs      = e_sreq && s_gnt;
      dest    = win;
      deliver = hs && s_rvalid;
    end
    e_rv[dest] = deliver;

    nx_pending = md_pending; nx_owner = md_owner; nx_favour = md_favour;
    nx_addr = md_addr; nx_we = md_we; nx_wdata = md_wdata; nx_be = md_be;
    if (!rstn) begin
      nx_pending = 1'b0; nx_owner = 1'b0; nx_favour = 1'b0;
      nx_addr = '0; nx_we = 1'b0; nx_wdata = '0; nx_be = '0;
      e_sreq = 1'b0; e_gnt[0] = 1'b0; e_gnt[1] = 1'b0;
      e_rv[0] = 1'b0; e_rv[1] = 1'b0;
    end else if (hs) begin
      nx_owner = win;
      nx_addr = la[win]; nx_we = lw[win]; nx_wdata = ld[win]; nx_be = lb[win];
      if (s_rvalid) nx_favour = ~win;
      else          nx_pending = 1'b1;
    end else if (md_pending && s_rvalid) begin
      nx_pending = 1'b0;
      nx_favour  = ~md_owner;
    end

    chk("m_s_req",     s_req,     e_sreq);
    chk("m_m0_gnt",    m0_gnt,    e_gnt[0]);
    chk("m_m1_gnt",    m1_gnt,    e_gnt[1]);
    chk("m_m0_rvalid", m0_rvalid, e_rv[0]);
    chk("m_m1_rvalid", m1_rvalid, e_rv[1]);
    chk("m_m0_err",    m0_err,    e_rv[0] && s_err);
    chk("m_m1_err",    m1_err,    e_rv[1] && s_err);
    chk("m_m0_rdata",  m0_rdata,  s_rdata);
    chk("m_m1_rdata",  m1_rdata,  s_rdata);
    chk("m_busy",      busy,      md_pending);
    chk("m_owner",     owner,     md_owner);
    if (e_sreq) begin
      chk("m_s_addr",  s_addr,  e_addr);
      chk("m_s_we",    s_we,    e_we);
      chk("m_s_wdata", s_wdata, e_wdata);
      chk("m_s_be",    s_be,    e_be);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_addr = '0; m1_addr = '0;
    m0_we = 0; m1_we = 0; m0_wdata = '0; m1_wdata = '0; m0_be = '0; m1_be = '0;
    s_gnt = 0; s_rvalid = 0; s_rdata = '0; s_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    tick(); tick();
    rstn = 1;
  endtask

  initial begin
    int busy_cnt, req_cnt;
    rstn = 0;
    idle_inputs();
    tick(); tick();
    // reset state while rstn low
    @(negedge clk);
    chk("rst_s_req", s_req, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_owner", owner, 0);
    tick();
    rstn = 1;

    // single master, zero latency
    m0_req = 1; m0_addr = 32'h10; s_gnt = 1; s_rvalid = 1; s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("zl_m0_gnt",    m0_gnt,    1);
    chk("zl_m0_rvalid", m0_rvalid, 1);
    chk("zl_m0_rdata",  m0_rdata,  32'hDEADBEEF);
    chk("zl_m1_gnt",    m1_gnt,    0);
    chk("zl_m1_rvalid", m1_rvalid, 0);
    chk("zl_busy",      busy,      0);
    tick();
    // priority now with m1: a tie goes to m1
    m1_req = 1; m1_addr = 32'h20;
    @(negedge clk);
    chk("zl_prio_m1_gnt", m1_gnt, 1);
    chk("zl_prio_m0_gnt", m0_gnt, 0);
    chk("zl_prio_addr",   s_addr, 32'h20);

    // contention, strict alternation from reset
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200;
    s_gnt = 1; s_rvalid = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ct_m0_gnt",    m0_gnt,    (i % 2) == 0);
      chk("ct_m1_gnt",    m1_gnt,    (i % 2) == 1);
      chk("ct_m0_rvalid", m0_rvalid, (i % 2) == 0);
      chk("ct_m1_rvalid", m1_rvalid, (i % 2) == 1);
      chk("ct_addr",      s_addr,    (i % 2) == 0 ? 32'h100 : 32'h200);
      tick();
    end

    // latency-3 write from m1, m0 address churning, error on response
    do_reset();
    busy_cnt = 0; req_cnt = 0;
    m1_req = 1; m1_addr = 32'h24; m1_we = 1; m1_wdata = 32'hCAFEF00D; m1_be = 4'hF;
    s_gnt = 1;
    for (int c = 0; c < 4; c++) begin
      m0_addr = $urandom;
      if (c == 3) begin s_rvalid = 1; s_err = 1; end
      @(negedge clk);
      chk("l3_s_addr",  s_addr, 32'h24);
      chk("l3_m0_gnt",  m0_gnt, 0);
      chk("l3_s_wdata", s_wdata, 32'hCAFEF00D);
      if (s_req) req_cnt++;
      if (busy)  busy_cnt++;
      if (c == 3) begin
        chk("er_m1_rvalid", m1_rvalid, 1);
        chk("er_m1_err",    m1_err,    1);
        chk("er_m0_err",    m0_err,    0);
        chk("er_m0_rvalid", m0_rvalid, 0);
      end
      tick();
      m1_req = 0; s_gnt = 0;
    end
    s_rvalid = 0; s_err = 0;
    @(negedge clk);
    chk("l3_req_cycles",  req_cnt,  4);
    chk("l3_busy_cycles", busy_cnt, 3);
    chk("er_m1_err_after", m1_err,  0);
    chk("l3_busy_after",  busy,     0);

    // reset mid-BUSY
    do_reset();
    m0_req = 1; m0_addr = 32'h50; s_gnt = 1;
    tick();
    m0_req = 0; s_gnt = 0;
    tick(); tick();
    #2;
    rstn = 0; s_rvalid = 1;
    #1;
    chk("rb_s_req",     s_req,     0);
    chk("rb_busy",      busy,      0);
    chk("rb_m0_rvalid", m0_rvalid, 0);
    chk("rb_m1_rvalid", m1_rvalid, 0);
    tick();
    rstn = 1; s_rvalid = 0;
    m0_req = 1; m1_req = 1; m0_addr = 32'h60; m1_addr = 32'h70; s_gnt = 1; s_rvalid = 1;
    @(negedge clk);
    chk("rb_first_m0_gnt", m0_gnt, 1);
    chk("rb_first_m1_gnt", m1_gnt, 0);

    // withdrawn request
    do_reset();
    m1_req = 1; m1_addr = 32'hBAD0;
    tick(); tick();
    m1_req = 0; m0_req = 1; m0_addr = 32'h40; s_gnt = 1;
    @(negedge clk);
    chk("wd_m0_gnt", m0_gnt, 1);
    chk("wd_m1_gnt", m1_gnt, 0);
    chk("wd_addr",   s_addr, 32'h40);
    tick();
    s_gnt = 0; m0_req = 0; s_rvalid = 1;
    tick();
    s_rvalid = 0;

    // random traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 3000; n++) begin
      rstn     = 1;
      m0_req   = ($urandom_range(0, 2) != 0);
      m1_req   = ($urandom_range(0, 2) != 0);
      m0_addr  = $urandom; m1_addr = $urandom;
      m0_we    = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
      m0_wdata = $urandom; m1_wdata = $urandom;
      m0_be    = BW'($urandom); m1_be = BW'($urandom);
      s_gnt    = $urandom_range(0, 1);
      s_rvalid = ($urandom_range(0, 4) < 2);
      s_rdata  = $urandom;
      s_err    = $urandom_range(0, 1);
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rstn = 0;
      end
      tick();
    end
    rstn = 1;
    idle_inputs();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obi_rr_arbiter.md
# obi_rr_arbiter

Two-requester OBI arbiter that shares the single core-side port of the data RAM (`raxi_dpram` core port) between two masters, e.g. a core load/store unit and a debug/DMA master. It runs in the core clock domain, allows exactly one outstanding transaction, and holds the downstream request until the response returns. This matches the memory's requirement that `req` stays asserted until `rvalid`. Round-robin priority prevents starvation.

## Interface
- `AddrWidth`, 32, address width, all ports
- `DataWidth`, 32, data width, all ports; byte-enable width is `DataWidth/8`
- `core_clk_i`  in  1  single clock; all state updates on its rising edge
- `rstn_i`  in  1  reset, asynchronous, active-low
- `m0_req_i` / `m1_req_i`  in  1  request from master 0 / 1
- `m0_gnt_o` / `m1_gnt_o`  out  1  grant to master 0 / 1
- `m0_addr_i` / `m1_addr_i`  in  AddrWidth  address
- `m0_we_i` / `m1_we_i`  in  1  write enable (1 = write)
- `m0_wdata_i` / `m1_wdata_i`  in  DataWidth  write data
- `m0_be_i` / `m1_be_i`  in  DataWidth/8  byte enables
- `m0_rvalid_o` / `m1_rvalid_o`  out  1  response valid
- `m0_rdata_o` / `m1_rdata_o`  out  DataWidth  read data
- `m0_err_o` / `m1_err_o`  out  1  error response
- `s_req_o`  out  1  downstream request
- `s_gnt_i`  in  1  downstream grant
- `s_addr_o`, `s_we_o`, `s_wdata_o`, `s_be_o`  out  downstream command; widths as above
- `s_rvalid_i`  in  1  downstream response valid
- `s_rdata_i`  in  DataWidth  downstream read data
- `s_err_i`  in  1  downstream error
- `busy_o`  out  1  transaction outstanding (state BUSY)
- `owner_o`  out  1  index of current or last granted master

## Operation
- States are IDLE and BUSY. Registers:
  - `state_q`
  - `owner_q` (1 bit)
  - `prio_q` (1 bit, master with priority on a tie)
  - command copy `addr_q`, `we_q`, `wdata_q`, `be_q`
- Selection in IDLE:
  - Only one `mX_req_i` high: select X.
  - Both high: select `prio_q`.
  - `sel` is combinational.
- IDLE outputs:
  - `s_req_o` = `m0_req_i | m1_req_i`.
  - `s_addr_o`, `s_we_o`, `s_wdata_o`, `s_be_o` = live signals of `sel`.
  - `m[sel]_gnt_o` = `s_gnt_i`; the other master's gnt = 0.
- Handshake in IDLE (`s_req_o && s_gnt_i`):
  - Latch the command into the `_q` copies and set `owner_q <= sel`.
  - If `s_rvalid_i` is low that cycle: go to BUSY.
  - If `s_rvalid_i` is high that cycle (zero-latency memory): the response goes to `sel` this cycle, state stays IDLE, and `prio_q <= ~sel`.
- BUSY:
  - `s_req_o` = 1, with command outputs driven from the `_q` copies.
  - Both `mX_gnt_o` = 0.
  - On `s_rvalid_i`: go to IDLE and set `prio_q <= ~owner_q`.
  - A new request is accepted at the earliest on the cycle after the response.
- Response routing:
  - `m[owner]_rvalid_o` = `s_rvalid_i`, where owner = `sel` in IDLE and `owner_q` in BUSY.
  - `mX_rdata_o` = `s_rdata_i` for both masters, unqualified.
  - `mX_err_o` = `s_err_i` gated by that master's rvalid.
  - The non-owner's rvalid and err = 0.
- A master that drops `req` before gnt is legal: selection re-evaluates every IDLE cycle with no lock.
- `s_rvalid_i` in IDLE without a handshake is ignored and never routed.
- `busy_o` = (`state_q` == BUSY). `owner_o` = `owner_q`.

## Timing
- Reset values (asynchronous):
  - `state_q` = IDLE, `owner_q` = 0, `prio_q` = 0.
  - `_q` copies = 0.
- While `rstn_i` = 0, `s_req_o`, all `mX_gnt_o`, all `mX_rvalid_o` and all `mX_err_o` are forced to 0; `busy_o` = 0, `owner_o` = 0.
- Reset asserted mid-BUSY: `s_req_o` drops immediately. The response is lost and no rvalid reaches any master.
- Timing paths:
  - `mX_req_i` to `s_req_o` is combinational (0 cycles).
  - `s_gnt_i` to `mX_gnt_o` is combinational.
  - `s_rvalid_i` to `mX_rvalid_o` is combinational.
- The arbiter adds no latency. Throughput is one transaction per response with a zero-latency memory. With a latency-N memory it is one transaction per N+1 cycles.
- Fairness: under continuous requests from both masters, grants alternate strictly, m0 first after reset.

## Test plan
- Single master, zero latency: m0 reads 0x10 with `s_gnt_i`=`s_rvalid_i`=1 and rdata 0xDEADBEEF → `m0_gnt_o` and `m0_rvalid_o` high in the same cycle with 0xDEADBEEF; m1 outputs stay 0; `prio_q` becomes 1.
- Contention: m0 and m1 requesting continuously for 6 transactions → grant order m0, m1, m0, m1, m0, m1; each master receives only its own rvalid.
- Latency-3 memory: m1 writes 0xCAFEF00D to 0x24 with be 0xF, while m0 changes its address every cycle → `s_addr_o` stays 0x24 and `s_req_o` stays high for 4 cycles until rvalid; m0 gnt is 0 throughout; `busy_o` is high for 3 cycles.
- Error routing: `s_err_i`=1 with the response to m1 → `m1_err_o`=1 for one cycle, `m0_err_o`=0.
- Reset mid-BUSY: assert `rstn_i`=0 two cycles into a latency-3 access → `s_req_o`, `busy_o` and all rvalids go 0 asynchronously; after release, the first grant goes to m0.
- Withdrawn request: m1 raises req with `s_gnt_i`=0 for 2 cycles, drops it, then m0 requests → m0 is granted, with no stale m1 command on `s_addr_o`.
